adc_spi_responder: RTL

- Synthesizable device-side model of the DE1 8-channel 12-bit serial ADC: it is the slave end of the ADC_SCLK / ADC_CS_N / ADC_DIN / ADC_DOUT link.
- It receives the 6-bit configuration word from the ADC controller and returns 12-bit samples taken from internal sample inputs.
- Used for on-board loopback and for closed-loop simulation of the ADC controller and the downstream FFT path without the physical converter.
- All link inputs are asynchronous to CLOCK; they are oversampled and edge-detected.

---
 rtl/adc_spi_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// Device-side model of the DE1 8-channel 12-bit serial ADC link.
// Oversamples SCLK/CS_N/DIN on CLOCK and answers frames from CH0..CH7.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ADC_SCLK,
  input  logic              ADC_CS_N,
  input  logic              ADC_DIN,
  output logic              ADC_DOUT,
  input  logic [DATA_W-1:0] CH0,
  input  logic [DATA_W-1:0] CH1,
  input  logic [DATA_W-1:0] CH2,
  input  logic [DATA_W-1:0] CH3,
  input  logic [DATA_W-1:0] CH4,
  input  logic [DATA_W-1:0] CH5,
  input  logic [DATA_W-1:0] CH6,
  input  logic [DATA_W-1:0] CH7,
  output logic [CFG_W-1:0]  CFG_WORD,
  output logic              CFG_VALID,
  output logic              FRAME_ERR,
  output logic [15:0]       FRAME_COUNT
);

  localparam int RXW = $clog2(CFG_W + 1);
  localparam int TXW = $clog2(DATA_W);
  localparam int STW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_FRAME
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [STW-1:0]         r_settle;

  logic w_sclk;
  logic w_cs;
  logic w_din;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_settled;

  logic [DATA_W-1:0] r_tx_shift;
  logic [TXW-1:0]    r_tx_cnt;
  logic [CFG_W-1:0]  r_rx_shift;
  logic [RXW-1:0]    r_rx_cnt;
  logic [2:0]        r_ch_sel;
  logic              r_dout;
  logic [CFG_W-1:0]  r_cfg_word;
  logic              r_cfg_valid;
  logic              r_frame_err;
  logic [15:0]       r_frame_count;
  logic [DATA_W-1:0] w_ch_data;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_din_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_settle    <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], ADC_DIN};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      if (!w_settled) r_settle <= r_settle + 1'b1;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  // The CS_N reset value is not a real observation of the pin.
  assign w_settled   = (r_settle == STW'(SYNC_STAGES));

  always_comb begin
    w_ch_data = CH0;
    case (r_ch_sel)
      3'd0:    w_ch_data = CH0;
      3'd1:    w_ch_data = CH1;
      3'd2:    w_ch_data = CH2;
      3'd3:    w_ch_data = CH3;
      3'd4:    w_ch_data = CH4;
      3'd5:    w_ch_data = CH5;
      3'd6:    w_ch_data = CH6;
      default: w_ch_data = CH7;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_state <= S_WAIT_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT_IDLE: if (w_settled && w_cs) w_next = S_IDLE;
      S_IDLE:      if (w_cs_fall) w_next = S_FRAME;
      S_FRAME:     if (w_cs_rise) w_next = S_IDLE;
      default:     w_next = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_tx_shift    <= '0;
      r_tx_cnt      <= '0;
      r_rx_shift    <= '0;
      r_rx_cnt      <= '0;
      r_ch_sel      <= '0;
      r_dout        <= 1'b0;
      r_cfg_word    <= '0;
      r_cfg_valid   <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_dout <= 1'b0;
          if (w_cs_fall) begin
            r_tx_shift <= w_ch_data;
            r_dout     <= w_ch_data[DATA_W-1];
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
          end
        end
        S_FRAME: begin
          // CS_N rise takes priority over any SCLK edge in the same cycle.
          if (w_cs_rise) begin
            r_dout <= 1'b0;
            if (r_rx_cnt == RXW'(CFG_W)) begin
              r_cfg_word    <= r_rx_shift;
              r_cfg_valid   <= 1'b1;
              r_ch_sel      <= {r_rx_shift[3], r_rx_shift[2], r_rx_shift[4]};
              r_frame_count <= r_frame_count + 16'd1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            if (r_rx_cnt < RXW'(CFG_W)) begin
              r_rx_shift <= {r_rx_shift[CFG_W-2:0], w_din};
              r_rx_cnt   <= r_rx_cnt + 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_tx_cnt < TXW'(DATA_W - 1)) begin
              r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
              r_dout     <= r_tx_shift[DATA_W-2];
              r_tx_cnt   <= r_tx_cnt + 1'b1;
            end else begin
              r_dout <= 1'b0;
            end
          end
        end
        default: r_dout <= 1'b0;
      endcase
    end
  end

  assign ADC_DOUT    = r_dout;
  assign CFG_WORD    = r_cfg_word;
  assign CFG_VALID   = r_cfg_valid;
  assign FRAME_ERR   = r_frame_err;
  assign FRAME_COUNT = r_frame_count;

endmodule
